// File: rtl/obi_arb_pkg.sv
// Shared types and limits for the OBI instruction/data arbiter.
package obi_arb_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    localparam int MAX_OUTSTANDING_LIMIT = 8;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// Source-ID FIFO: remembers which port owns each outstanding memory transaction.
module obi_arb_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push,
    input  src_e             i_push_id,
    input  logic             i_pop,
    output src_e             o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    src_e             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == {CNT_W{1'b0}});
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= SRC_INSTR;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wptr] <= i_push_id;
                r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : r_wptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : r_rptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/obi_ifdata_arbiter.sv
// Round-robin arbiter sharing one OBI memory between fetch and data ports.
// Optional stall/conflict counters enabled by defining OBI_ARB_PERF_CNT_EN.
module obi_ifdata_arbiter
    import obi_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    instr_req_i,
    output logic                    instr_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
`ifdef OBI_ARB_PERF_CNT_EN
    output logic [31:0]             instr_stall_cnt_o,
    output logic [31:0]             data_stall_cnt_o,
    output logic [31:0]             conflict_cnt_o,
`endif
    output logic                    err_o
);

    localparam int DEPTH = (MAX_OUTSTANDING > MAX_OUTSTANDING_LIMIT) ? MAX_OUTSTANDING_LIMIT : MAX_OUTSTANDING;
    localparam int CNT_W = $clog2(DEPTH + 1);

    src_e             r_last_grant;
    src_e             r_lock_src;
    logic             r_lock;
    logic             r_err;
    src_e             w_winner;
    src_e             w_head;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_win_req;
    logic             w_hs;
    logic             w_pop;

    // A locked winner holds until granted; otherwise the port not granted last wins ties.
    always_comb begin
        w_winner = SRC_DATA;
        if (r_lock) begin
            w_winner = r_lock_src;
        end else if (instr_req_i && data_req_i) begin
            w_winner = (r_last_grant == SRC_DATA) ? SRC_INSTR : SRC_DATA;
        end else if (instr_req_i) begin
            w_winner = SRC_INSTR;
        end else begin
            w_winner = SRC_DATA;
        end
    end

    assign w_win_req = (w_winner == SRC_INSTR) ? instr_req_i : data_req_i;
    // A pop in this cycle deliberately does not free a slot: gnt stays off the rvalid path.
    assign mem_req_o = rst_ni & w_win_req & ~w_full;
    assign w_hs      = mem_req_o & mem_gnt_i;

    assign instr_gnt_o = w_hs & (w_winner == SRC_INSTR);
    assign data_gnt_o  = w_hs & (w_winner == SRC_DATA);

    assign mem_addr_o  = (w_winner == SRC_INSTR) ? instr_addr_i : data_addr_i;
    assign mem_be_o    = (w_winner == SRC_INSTR) ? {(DATA_WIDTH/8){1'b1}} : data_be_i;
    assign mem_we_o    = (w_winner == SRC_INSTR) ? 1'b0 : data_we_i;
    assign mem_wdata_o = (w_winner == SRC_INSTR) ? {DATA_WIDTH{1'b0}} : data_wdata_i;

    assign w_pop          = rst_ni & mem_rvalid_i & ~w_empty;
    assign instr_rvalid_o = w_pop & (w_head == SRC_INSTR);
    assign data_rvalid_o  = w_pop & (w_head == SRC_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign err_o          = rst_ni & r_err;

    obi_arb_id_fifo #(
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_push    (w_hs),
        .i_push_id (w_winner),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    // Grant history, winner lock and sticky unexpected-response flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_last_grant <= SRC_DATA;
            r_lock_src   <= SRC_DATA;
            r_lock       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_hs) begin
                r_last_grant <= w_winner;
                r_lock       <= 1'b0;
            end else if (mem_req_o) begin
                r_lock     <= 1'b1;
                r_lock_src <= w_winner;
            end else begin
                r_lock <= r_lock;
            end
            if (mem_rvalid_i && (w_count == {CNT_W{1'b0}})) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef OBI_ARB_PERF_CNT_EN
    logic [31:0] r_instr_stall_cnt;
    logic [31:0] r_data_stall_cnt;
    logic [31:0] r_conflict_cnt;

    assign instr_stall_cnt_o = r_instr_stall_cnt;
    assign data_stall_cnt_o  = r_data_stall_cnt;
    assign conflict_cnt_o    = r_conflict_cnt;

    // Saturating stall and conflict counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_instr_stall_cnt <= 32'd0;
            r_data_stall_cnt  <= 32'd0;
            r_conflict_cnt    <= 32'd0;
        end else begin
            if (instr_req_i && !instr_gnt_o && (r_instr_stall_cnt != 32'hFFFF_FFFF)) begin
                r_instr_stall_cnt <= r_instr_stall_cnt + 32'd1;
            end
            if (data_req_i && !data_gnt_o && (r_data_stall_cnt != 32'hFFFF_FFFF)) begin
                r_data_stall_cnt <= r_data_stall_cnt + 32'd1;
            end
            if (instr_req_i && data_req_i && !r_lock && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_obi_ifdata_arbiter.sv
// Directed self-checking bench for obi_ifdata_arbiter (MAX_OUTSTANDING=2).
module tb_obi_ifdata_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_i;
    logic        instr_gnt_o;
    logic [31:0] instr_addr_i;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic        data_gnt_o;
    logic [31:0] data_addr_i;
    logic [3:0]  data_be_i;
    logic        data_we_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;
`ifdef OBI_ARB_PERF_CNT_EN
    logic [31:0] instr_stall_cnt_o;
    logic [31:0] data_stall_cnt_o;
    logic [31:0] conflict_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    obi_ifdata_arbiter #(
        .MAX_OUTSTANDING (2),
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_addr_i    (data_addr_i),
        .data_be_i      (data_be_i),
        .data_we_i      (data_we_i),
        .data_wdata_i   (data_wdata_i),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_addr_o     (mem_addr_o),
        .mem_be_o       (mem_be_o),
        .mem_we_o       (mem_we_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
`ifdef OBI_ARB_PERF_CNT_EN
        .instr_stall_cnt_o (instr_stall_cnt_o),
        .data_stall_cnt_o  (data_stall_cnt_o),
        .conflict_cnt_o    (conflict_cnt_o),
`endif
        .err_o          (err_o)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_addr_i  = 32'h0;
        data_be_i    = 4'h0;
        data_we_i    = 1'b0;
        data_wdata_i = 32'h0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
        #1;
        total++;
        if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o} !== 6'b0) begin
            $display("FAIL reset_outputs got=%b exp=000000",
                     {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o});
            bad++;
        end
        do_reset();
    endtask

    task automatic test_instr_only();
        instr_req_i = 1'b1; instr_addr_i = 32'h100; mem_gnt_i = 1'b1;
        #1;
        total++;
        if ({mem_req_o, instr_gnt_o, data_gnt_o} !== 3'b110 || mem_addr_o !== 32'h100 ||
            mem_be_o !== 4'hF || mem_we_o !== 1'b0 || mem_wdata_o !== 32'h0) begin
            $display("FAIL instr_first req/gi/gd=%b%b%b addr=%h be=%h we=%b wd=%h exp 110 100 f 0 0",
                     mem_req_o, instr_gnt_o, data_gnt_o, mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o);
            bad++;
        end
        tick();
        instr_addr_i = 32'h104; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_1111;
        #1;
        total++;
        if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h104 || instr_rvalid_o !== 1'b1 ||
            data_rvalid_o !== 1'b0 || instr_rdata_o !== 32'h1111_1111) begin
            $display("FAIL instr_second gnt=%b addr=%h irv=%b drv=%b rdata=%h exp 1 104 1 0 11111111",
                     instr_gnt_o, mem_addr_o, instr_rvalid_o, data_rvalid_o, instr_rdata_o);
            bad++;
        end
        tick();
        instr_req_i = 1'b0; mem_rdata_i = 32'h2222_2222;
        #1;
        total++;
        if (mem_req_o !== 1'b0 || instr_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0 ||
            data_rdata_o !== 32'h2222_2222) begin
            $display("FAIL instr_last_resp req=%b irv=%b drv=%b drdata=%h exp 0 1 0 22222222",
                     mem_req_o, instr_rvalid_o, data_rvalid_o, data_rdata_o);
            bad++;
        end
        tick();
        idle_inputs();
        #1;
        total++;
        if (err_o !== 1'b0) begin
            $display("FAIL instr_no_err got=%b exp=0", err_o);
            bad++;
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        instr_addr_i = 32'h200; data_addr_i = 32'h300; data_be_i = 4'hF; mem_gnt_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            logic exp_gi, exp_gd, exp_ri, exp_rd;
            logic [31:0] exp_addr;
            instr_req_i  = (c < 4);
            data_req_i   = (c < 4);
            mem_rvalid_i = (c >= 1);
            mem_rdata_i  = 32'hA000_0000 + 32'(c);
            exp_gi   = (c < 4) && (c % 2 == 0);
            exp_gd   = (c < 4) && (c % 2 == 1);
            exp_ri   = (c >= 1) && ((c - 1) % 2 == 0);
            exp_rd   = (c >= 1) && ((c - 1) % 2 == 1);
            exp_addr = (c % 2 == 0) ? 32'h200 : 32'h300;
            #1;
            total++;
            if (instr_gnt_o !== exp_gi || data_gnt_o !== exp_gd || instr_rvalid_o !== exp_ri ||
                data_rvalid_o !== exp_rd || ((c < 4) && mem_addr_o !== exp_addr)) begin
                $display("FAIL rr_cycle%0d gi=%b gd=%b ri=%b rd=%b addr=%h exp %b %b %b %b %h",
                         c, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, mem_addr_o,
                         exp_gi, exp_gd, exp_ri, exp_rd, exp_addr);
                bad++;
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        data_req_i = 1'b1; data_addr_i = 32'h800; data_be_i = 4'hF; mem_gnt_i = 1'b0;
        instr_addr_i = 32'h900;
        for (int c = 0; c < 3; c++) begin
            instr_req_i = (c >= 1);
            #1;
            total++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h800 || instr_gnt_o !== 1'b0 || data_gnt_o !== 1'b0) begin
                $display("FAIL lock_hold%0d req=%b addr=%h gi=%b gd=%b exp 1 800 0 0",
                         c, mem_req_o, mem_addr_o, instr_gnt_o, data_gnt_o);
                bad++;
            end
            tick();
        end
        mem_gnt_i = 1'b1;
        #1;
        total++;
        if (data_gnt_o !== 1'b1 || instr_gnt_o !== 1'b0 || mem_addr_o !== 32'h800) begin
            $display("FAIL lock_release gd=%b gi=%b addr=%h exp 1 0 800", data_gnt_o, instr_gnt_o, mem_addr_o);
            bad++;
        end
        tick();
        data_req_i = 1'b0;
        #1;
        total++;
        if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h900) begin
            $display("FAIL lock_instr_next gi=%b addr=%h exp 1 900", instr_gnt_o, mem_addr_o);
            bad++;
        end
        tick();
        instr_req_i = 1'b0; mem_rvalid_i = 1'b1;
        #1;
        total++;
        if (data_rvalid_o !== 1'b1 || instr_rvalid_o !== 1'b0) begin
            $display("FAIL lock_resp1 drv=%b irv=%b exp 1 0", data_rvalid_o, instr_rvalid_o);
            bad++;
        end
        tick();
        #1;
        total++;
        if (instr_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0) begin
            $display("FAIL lock_resp2 irv=%b drv=%b exp 1 0", instr_rvalid_o, data_rvalid_o);
            bad++;
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_outstanding();
        do_reset();
        instr_req_i = 1'b1; instr_addr_i = 32'h40; mem_gnt_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (instr_gnt_o !== (c < 2) || mem_req_o !== (c < 2)) begin
                $display("FAIL limit_cycle%0d gnt=%b req=%b exp %b", c, instr_gnt_o, mem_req_o, (c < 2));
                bad++;
            end
            tick();
        end
        mem_rvalid_i = 1'b1;
        #1;
        total++;
        if (instr_rvalid_o !== 1'b1 || mem_req_o !== 1'b0 || instr_gnt_o !== 1'b0) begin
            $display("FAIL limit_same_cycle rv=%b req=%b gnt=%b exp 1 0 0", instr_rvalid_o, mem_req_o, instr_gnt_o);
            bad++;
        end
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        total++;
        if (instr_gnt_o !== 1'b1 || mem_req_o !== 1'b1) begin
            $display("FAIL limit_next_cycle gnt=%b req=%b exp 1 1", instr_gnt_o, mem_req_o);
            bad++;
        end
        tick();
        instr_req_i = 1'b0; mem_rvalid_i = 1'b1;
        tick();
        tick();
        idle_inputs();
        #1;
        total++;
        if (err_o !== 1'b0) begin
            $display("FAIL limit_drain_err got=%b exp=0", err_o);
            bad++;
        end
    endtask

    task automatic test_err();
        do_reset();
        mem_rvalid_i = 1'b1;
        #1;
        total++;
        if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0 || err_o !== 1'b0) begin
            $display("FAIL err_spurious irv=%b drv=%b err=%b exp 0 0 0", instr_rvalid_o, data_rvalid_o, err_o);
            bad++;
        end
        tick();
        mem_rvalid_i = 1'b0;
        tick();
        tick();
        total++;
        if (err_o !== 1'b1) begin
            $display("FAIL err_sticky got=%b exp=1", err_o);
            bad++;
        end
        rst_ni = 1'b0;
        #1;
        total++;
        if (err_o !== 1'b0) begin
            $display("FAIL err_in_reset got=%b exp=0", err_o);
            bad++;
        end
        tick();
        rst_ni = 1'b1;
        tick();
        total++;
        if (err_o !== 1'b0) begin
            $display("FAIL err_after_reset got=%b exp=0", err_o);
            bad++;
        end
    endtask

    task automatic test_write_interleave();
        do_reset();
        instr_req_i = 1'b1; instr_addr_i = 32'h400;
        data_req_i = 1'b1; data_addr_i = 32'h500; data_be_i = 4'b0011; data_we_i = 1'b1;
        data_wdata_i = 32'hDEAD_BEEF; mem_gnt_i = 1'b1;
        #1;
        total++;
        if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h400 || mem_be_o !== 4'hF ||
            mem_we_o !== 1'b0 || mem_wdata_o !== 32'h0) begin
            $display("FAIL wr_fetch gi=%b addr=%h be=%h we=%b wd=%h exp 1 400 f 0 0",
                     instr_gnt_o, mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o);
            bad++;
        end
        tick();
        mem_rvalid_i = 1'b1;
        #1;
        total++;
        if (data_gnt_o !== 1'b1 || mem_addr_o !== 32'h500 || mem_be_o !== 4'b0011 ||
            mem_we_o !== 1'b1 || mem_wdata_o !== 32'hDEAD_BEEF || instr_rvalid_o !== 1'b1) begin
            $display("FAIL wr_data gd=%b addr=%h be=%h we=%b wd=%h irv=%b exp 1 500 3 1 deadbeef 1",
                     data_gnt_o, mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o, instr_rvalid_o);
            bad++;
        end
        tick();
        instr_req_i = 1'b0; data_req_i = 1'b0;
        #1;
        total++;
        if (data_rvalid_o !== 1'b1 || instr_rvalid_o !== 1'b0) begin
            $display("FAIL wr_resp drv=%b irv=%b exp 1 0", data_rvalid_o, instr_rvalid_o);
            bad++;
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        test_reset();
        test_instr_only();
        test_round_robin();
        test_lock();
        test_outstanding();
        test_write_interleave();
        test_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/obi_ifdata_arbiter.md
Name: obi_ifdata_arbiter

Overview:
- Shares one single-port OBI memory between the core's instruction-fetch and data OBI ports.
- Sits between cv32e40x_core and a single-ported SRAM/bus slave.
- Round-robin arbitration of address phases; in-order routing of response phases via a source-ID FIFO.
- Bounds outstanding transactions.

Parameters:
- MAX_OUTSTANDING, 2: max accepted-but-unanswered transactions (1..8).
- ADDR_WIDTH, 32: address width of all ports.
- DATA_WIDTH, 32: data width of all ports; byte enables are DATA_WIDTH/8 wide.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous, active-low reset.
- instr_req_i  in  1  fetch request.
- instr_gnt_o  out  1  fetch grant.
- instr_addr_i  in  ADDR_WIDTH  fetch address.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  DATA_WIDTH  fetch read data.
- data_req_i  in  1  data request.
- data_gnt_o  out  1  data grant.
- data_addr_i  in  ADDR_WIDTH  data address.
- data_be_i  in  DATA_WIDTH/8  byte enables.
- data_we_i  in  1  write enable.
- data_wdata_i  in  DATA_WIDTH  write data.
- data_rvalid_o  out  1  data response valid.
- data_rdata_o  out  DATA_WIDTH  data read data.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory grant.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_be_o  out  DATA_WIDTH/8  memory byte enables.
- mem_we_o  out  1  memory write enable.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_rvalid_i  in  1  memory response valid.
- mem_rdata_i  in  DATA_WIDTH  memory read data.
- err_o  out  1  sticky protocol error.

Behaviour:
- One clock clk_i. Reset rst_ni is synchronous, active-low.
- While rst_ni is low, these outputs are forced 0: mem_req_o, *_gnt_o, *_rvalid_o, err_o.
- Registered state at reset:
  - outstanding count = 0
  - FIFO empty
  - last_grant = SRC_DATA, so instr wins the first tie
  - lock = 0
- Address phase (combinational path req -> mem_req_o, mem_gnt_i -> gnt):
  - A slot is free when count < MAX_OUTSTANDING.
  - A same-cycle pop does NOT free a slot; this keeps the gnt path short.
  - No free slot: mem_req_o=0 and both gnt=0.
  - Winner selection: only one requester -> it wins. Both requesting -> the source != last_grant wins.
  - mem_* is driven from the winner.
  - For instr: mem_be_o = all ones, mem_we_o=0, mem_wdata_o=0.
- Winner lock (OBI stability):
  - If mem_req_o=1 and mem_gnt_i=0, lock<=1 and the selection is frozen until mem_gnt_i.
  - A newly arriving other requester cannot preempt a locked winner.
- Handshake (mem_req_o & mem_gnt_i):
  - Winner's gnt_o=1.
  - Push winner ID into the FIFO; count+1.
  - last_grant<=winner; lock<=0.
- Response phase:
  - mem_rvalid_i pops the FIFO head.
  - The head source gets rvalid_o=1 (same cycle, combinational) and rdata_o=mem_rdata_i; the other rvalid_o=0.
  - rdata_o of both ports always mirrors mem_rdata_i.
- Simultaneous push and pop: count unchanged, FIFO pointers both advance.
- Responses return in order; the slave must preserve order.
- mem_rvalid_i with count==0:
  - No rvalid_o asserted; err_o<=1, sticky until reset.
  - A response in the same cycle as the first grant (count 0) is also an error; zero-latency responses are not supported.
- Reset mid-operation: outstanding IDs are discarded. A memory that is not reset together would trigger err_o on late responses.
- Pointer widths: $clog2(MAX_OUTSTANDING) with explicit wrap at MAX_OUTSTANDING-1; non-power-of-2 depths are legal. Count width is $clog2(MAX_OUTSTANDING+1).

Optional Feature:
- Macro OBI_ARB_PERF_CNT_EN.
- When defined, adds outputs:
  - instr_stall_cnt_o (32): cycles instr_req_i=1 and instr_gnt_o=0.
  - data_stall_cnt_o (32): same for the data port.
  - conflict_cnt_o (32): cycles both req high with no lock held.
- Counters reset to 0, saturate at 32'hFFFF_FFFF, and count only while rst_ni=1.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package obi_arb_pkg:
  - typedef enum logic {SRC_INSTR=1'b0, SRC_DATA=1'b1} src_e
  - localparam MAX_OUTSTANDING_LIMIT=8
- Sub-module obi_arb_id_fifo (DEPTH param, src_e payload, push/pop/full/empty/count, synchronous active-low reset). Top contains arbitration, lock, muxing, error flag.

Test Plan:
- Only instr requests addr 0x100, 0x104, mem gnt immediate, rvalid 1 cycle later -> instr_gnt_o each cycle, two instr_rvalid_o pulses, data_rvalid_o never.
- Both requesting every cycle, mem_gnt_i=1, rvalid lag 1 -> grants alternate I,D,I,D starting with instr; rvalids routed in the same order.
- data req with mem_gnt_i held 0 for 3 cycles, instr req raised in cycle 2 -> mem_addr_o stays data addr until grant; instr granted next.
- MAX_OUTSTANDING=2, mem_gnt_i=1, no rvalid -> exactly 2 grants then mem_req_o=0; one rvalid -> one more grant the following cycle, not the same cycle.
- mem_rvalid_i pulse after reset with nothing outstanding -> no port rvalid, err_o=1 and held until rst_ni low.
- Write via data port (be=4'b0011, we=1, wdata=0xDEADBEEF) interleaved with fetch -> mem_* fields match the winner exactly; fetch shows be=4'hF, we=0.
